cpu_fetch_unit: RTL

//   Instruction fetch front end for the 19-bit CPU. Sits directly upstream of cpu_top decode.

---
 rtl/cpu_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch front end: issues word addresses to instruction memory, buffers in-order
// responses in a small prefetch queue and hands {instr, pc} to decode.
module cpu_fetch_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 19,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic               protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // valid never depends on ready; imem_rsp has no ready and must always be taken.

    logic [ADDR_W-1:0]  fetch_pc_q;
    logic [ADDR_W-1:0]  rsp_pc_q;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               protocol_err_q;
    logic [INSTR_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0]  q_pc   [DEPTH];

    logic [CNT_W:0]     credit_used;
    logic               req_fire;
    logic               rsp_fire;
    logic               rsp_discard;
    logic               push;
    logic               pop;

    // Queued entries plus outstanding fetches never exceed DEPTH, so a push never hits a full queue.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = reset && !halt && !redirect_valid &&
                            (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign fetch_pc       = fetch_pc_q;
    assign protocol_err   = protocol_err_q;

    assign req_fire    = imem_req_valid && imem_req_ready;
    assign rsp_fire    = imem_rsp_valid && (inflight != '0);
    assign rsp_discard = (drop != '0) || redirect_valid;
    assign push        = rsp_fire && !rsp_discard;

    assign instr_valid = (count != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instr_data  = (count != '0) ? q_data[rd_ptr] : '0;
    assign instr_pc    = (count != '0) ? q_pc[rd_ptr]   : '0;

    // rsp_pc_q is the address of the next response that will be kept; discarded ones do not advance it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q     <= RESET_PC;
            rsp_pc_q       <= RESET_PC;
            count          <= '0;
            inflight       <= '0;
            drop           <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (imem_rsp_valid && (inflight == '0))
                protocol_err_q <= 1'b1;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
                rsp_pc_q   <= redirect_pc;
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                inflight   <= inflight - CNT_W'(rsp_fire);
                drop       <= inflight - CNT_W'(rsp_fire);
            end else begin
                if (req_fire)
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
                inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_fire);
                if (rsp_fire && (drop != '0))
                    drop <= drop - CNT_W'(1);
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    rsp_pc_q <= rsp_pc_q + ADDR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Entry storage needs no reset: reads are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc_q;
        end
    end

endmodule
